stat_sprite_writer: RTL and testbench

//  Write side of the static sprite store: accepts a byte stream for one 16x16, 2-bit sprite,

---
 rtl/stat_sprite_writer.sv | 161 ++++++++++++++++
 tb/tb_stat_sprite_writer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stat_sprite_writer.sv
// Write side of the static sprite store: unpacks a 64-byte stream (four 2-bit pixels per
// byte, LSBs first) into 256 pixel writes on the write port of the selected sprite RAM.
module stat_sprite_writer #(
   parameter int NUM_SPRITES    = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic [5:0]             select,
   input  logic [7:0]             data_in,
   input  logic                   data_valid,
   output logic                   data_ready,
   output logic [NUM_SPRITES-1:0] wr_en,
   output logic [7:0]             wr_address,
   output logic [1:0]             wr_data,
   output logic                   busy,
   output logic                   done,
   output logic                   error,
   output logic [2:0]             dbg_state
);

   localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [6:0]    NUM_SEL  = 7'(NUM_SPRITES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_WRITE = 3'd2,
      S_DONE  = 3'd3,
      S_ERR   = 3'd4
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [5:0]             r_sel;
   logic [5:0]             w_sel_nxt;
   logic [7:0]             r_byte;
   logic [7:0]             w_byte_nxt;
   logic [7:0]             r_pix_cnt;
   logic [7:0]             w_pix_nxt;
   logic [TW-1:0]          r_to_cnt;
   logic [TW-1:0]          w_to_nxt;
   logic [NUM_SPRITES-1:0] w_onehot;
   logic [1:0]             w_pix_val;

   logic                   r_data_ready;
   logic [NUM_SPRITES-1:0] r_wr_en;
   logic [7:0]             r_wr_address;
   logic [1:0]             r_wr_data;
   logic                   r_busy;
   logic                   r_done;
   logic                   r_error;

   // Handshake (valid/ready): a byte transfers on a rising clock edge where data_valid and
   // data_ready are both high. data_ready is high in every LOAD cycle and in no other state;
   // the source may hold or change data_valid freely, nothing is taken while data_ready is low.

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_byte_nxt  = r_byte;
      w_pix_nxt   = r_pix_cnt;
      w_to_nxt    = r_to_cnt;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if ({1'b0, select} < NUM_SEL) begin
                  w_state_nxt = S_LOAD;
                  w_sel_nxt   = select;
                  w_pix_nxt   = 8'd0;
                  w_to_nxt    = '0;
               end else begin
                  w_state_nxt = S_ERR;
               end
            end
         end
         S_LOAD: begin
            if (data_valid && r_data_ready) begin
               w_byte_nxt  = data_in;
               w_to_nxt    = '0;
               w_state_nxt = S_WRITE;
            end else if (r_to_cnt == TO_LAST) begin
               w_state_nxt = S_ERR;
            end else begin
               w_to_nxt = r_to_cnt + TW'(1);
            end
         end
         S_WRITE: begin
            // r_pix_cnt is the address on the port this cycle; the low two bits pick the pixel
            w_pix_nxt = r_pix_cnt + 8'd1;
            if (r_pix_cnt[1:0] == 2'd3) begin
               w_state_nxt = (r_pix_cnt == 8'hFF) ? S_DONE : S_LOAD;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         S_ERR:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_onehot = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         w_onehot[i] = (w_sel_nxt == 6'(i));
      end
   end

   always_comb begin
      w_pix_val = 2'b00;
      case (w_pix_nxt[1:0])
         2'd0: w_pix_val = w_byte_nxt[1:0];
         2'd1: w_pix_val = w_byte_nxt[3:2];
         2'd2: w_pix_val = w_byte_nxt[5:4];
         2'd3: w_pix_val = w_byte_nxt[7:6];
         default: w_pix_val = 2'b00;
      endcase
   end

   // Outputs are registered from next-state values so they line up with the state they describe.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_sel        <= 6'd0;
         r_byte       <= 8'd0;
         r_pix_cnt    <= 8'd0;
         r_to_cnt     <= '0;
         r_data_ready <= 1'b0;
         r_wr_en      <= '0;
         r_wr_address <= 8'd0;
         r_wr_data    <= 2'b00;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_sel        <= w_sel_nxt;
         r_byte       <= w_byte_nxt;
         r_pix_cnt    <= w_pix_nxt;
         r_to_cnt     <= w_to_nxt;
         r_data_ready <= (w_state_nxt == S_LOAD);
         r_wr_en      <= (w_state_nxt == S_WRITE) ? w_onehot : '0;
         r_wr_address <= w_pix_nxt;
         r_wr_data    <= (w_state_nxt == S_WRITE) ? w_pix_val : 2'b00;
         r_busy       <= (w_state_nxt != S_IDLE);
         r_done       <= (w_state_nxt == S_DONE);
         r_error      <= (w_state_nxt == S_ERR);
      end
   end

   assign data_ready = r_data_ready;
   assign wr_en      = r_wr_en;
   assign wr_address = r_wr_address;
   assign wr_data    = r_wr_data;
   assign busy       = r_busy;
   assign done       = r_done;
   assign error      = r_error;
   assign dbg_state  = r_state;

endmodule

// File: tb/tb_stat_sprite_writer.sv
// Bench for stat_sprite_writer: randomized sprite uploads against a pixel-image model, with a
// write scoreboard, bad-select, timeout and mid-upload reset scenarios.
module tb_stat_sprite_writer;

   localparam int NS = 2;
   localparam int TO = 1024;
   localparam int EW = NS + 10;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [5:0]    select = 6'd0;
   logic [7:0]    data_in = 8'd0;
   logic          data_valid = 1'b0;
   logic          data_ready;
   logic [NS-1:0] wr_en;
   logic [7:0]    wr_address;
   logic [1:0]    wr_data;
   logic          busy;
   logic          done;
   logic          error;
   logic [2:0]    dbg_state;

   stat_sprite_writer #(.NUM_SPRITES(NS), .TIMEOUT_CYCLES(TO)) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .select     (select),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .wr_en      (wr_en),
      .wr_address (wr_address),
      .wr_data    (wr_data),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .dbg_state  (dbg_state)
   );

   always #5 clock = ~clock;

   int            tests = 0;
   int            fails = 0;
   int            done_cnt = 0;
   int            err_cnt = 0;
   logic [EW-1:0] exp_q[$];
   logic [1:0]    mem [NS][256];
   logic [1:0]    img [NS][256];
   logic [7:0]    bytes_q [64];
   bit            hs_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic finish_now();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "bench aborted");
   endtask

   // Monitor: every write must match the head of the expected queue.
   always @(negedge clock) begin
      logic [EW-1:0] e;
      if (reset) begin
         hs_prev = 1'b0;
      end else begin
         if (hs_prev) begin
            tests++;
            if (wr_en == '0) begin
               fails++;
               $display("FAIL latency: wr_en=%b one cycle after handshake, required nonzero", wr_en);
            end
         end
         if (wr_en != '0) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_write: got en=%b addr=%0d data=%0d, required no write",
                        wr_en, wr_address, wr_data);
            end else begin
               e = exp_q.pop_front();
               if ({wr_en, wr_address, wr_data} !== e) begin
                  fails++;
                  $display("FAIL write: got en=%b addr=%0d data=%0d, required en=%b addr=%0d data=%0d",
                           wr_en, wr_address, wr_data, e[EW-1:10], e[9:2], e[1:0]);
               end
            end
            for (int i = 0; i < NS; i++) begin
               if (wr_en[i]) mem[i][wr_address] = wr_data;
            end
         end
         if (done) done_cnt++;
         if (error) err_cnt++;
         hs_prev = data_valid && data_ready;
      end
   end

   // Model: byte b carries pixels 4b..4b+3, LSB pair first; pixel k lands at address k.
   task automatic make_sprite(input int sel, input bit fixed_e4, input int n_exp);
      logic [1:0]    px;
      logic [NS-1:0] oh;
      for (int b = 0; b < 64; b++) bytes_q[b] = fixed_e4 ? 8'hE4 : 8'($urandom);
      oh = NS'(1) << sel;
      for (int k = 0; k < n_exp; k++) begin
         px = 2'((bytes_q[k / 4] >> (2 * (k % 4))) & 8'h03);
         exp_q.push_back({oh, 8'(k), px});
         img[sel][k] = px;
      end
   endtask

   task automatic start_upload(input int sel);
      start  = 1'b1;
      select = 6'(sel);
      @(posedge clock);
      #1;
      start  = 1'b0;
      select = 6'($urandom);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps, input bit allow_start);
      bit acc;
      int guard;
      acc   = 1'b0;
      guard = 0;
      while (!acc) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            data_valid = 1'b0;
            data_in    = 8'($urandom);
         end else begin
            data_valid = 1'b1;
            data_in    = b;
         end
         start  = allow_start ? ($urandom_range(0, 3) == 0) : 1'b0;
         select = 6'($urandom);
         @(negedge clock);
         acc = data_valid && data_ready;
         @(posedge clock);
         #1;
         guard++;
         if (guard > 2000) begin
            tests++;
            fails++;
            $display("FAIL byte_accept: no handshake within 2000 cycles, required acceptance");
            finish_now();
         end
      end
      data_valid = 1'b0;
      start      = 1'b0;
   endtask

   task automatic full_upload(input int sel, input bit fixed_e4, input bit gaps, input string tag);
      int d0;
      int guard;
      int bad;
      make_sprite(sel, fixed_e4, 256);
      d0 = done_cnt;
      start_upload(sel);
      for (int b = 0; b < 64; b++) send_byte(bytes_q[b], gaps, gaps && (b < 63));
      guard = 0;
      while (done_cnt == d0 && guard < 40) begin
         @(negedge clock);
         guard++;
      end
      repeat (6) @(negedge clock);
      check({tag, " done_count"}, 32'(done_cnt - d0), 32'd1);
      check({tag, " queue_empty"}, 32'(exp_q.size()), 32'd0);
      check({tag, " busy_after"}, 32'(busy), 32'd0);
      bad = 0;
      for (int k = 0; k < 256; k++) if (mem[sel][k] !== img[sel][k]) bad++;
      check({tag, " readback_mismatches"}, 32'(bad), 32'd0);
   endtask

   initial begin
      int e0;
      int d0;
      int k_err;

      // Reset held 3 cycles: every output low, FSM idle.
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst data_ready", 32'(data_ready), 32'd0);
      check("rst wr_en", 32'(wr_en), 32'd0);
      check("rst wr_address", 32'(wr_address), 32'd0);
      check("rst wr_data", 32'(wr_data), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst error", 32'(error), 32'd0);
      check("rst state", 32'(dbg_state), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      check("post_rst busy", 32'(busy), 32'd0);
      check("post_rst data_ready", 32'(data_ready), 32'd0);

      full_upload(1, 1'b1, 1'b0, "full_e4");

      for (int r = 0; r < 4; r++) full_upload($urandom_range(0, NS - 1), 1'b0, 1'b1, "rand_bp");

      // Out-of-range selects abort without writing.
      for (int r = 0; r < 4; r++) begin
         e0 = err_cnt;
         start_upload((r == 0) ? 5 : $urandom_range(NS, 63));
         @(negedge clock);
         check("badsel error", 32'(error), 32'd1);
         check("badsel busy", 32'(busy), 32'd1);
         @(negedge clock);
         check("badsel error_low", 32'(error), 32'd0);
         check("badsel busy_low", 32'(busy), 32'd0);
         check("badsel err_pulses", 32'(err_cnt - e0), 32'd1);
      end

      // Timeout: 3 bytes then silence; ERR lands TO idle LOAD cycles after the 4 writes.
      make_sprite(0, 1'b0, 12);
      e0 = err_cnt;
      d0 = done_cnt;
      start_upload(0);
      for (int b = 0; b < 3; b++) send_byte(bytes_q[b], 1'b0, 1'b0);
      k_err = -1;
      for (int k = 0; k <= TO + 30; k++) begin
         @(negedge clock);
         if (error) begin
            k_err = k;
            break;
         end
      end
      check("timeout error_cycle", 32'(k_err), 32'(TO + 4));
      @(negedge clock);
      check("timeout busy_low", 32'(busy), 32'd0);
      check("timeout err_pulses", 32'(err_cnt - e0), 32'd1);
      check("timeout no_done", 32'(done_cnt - d0), 32'd0);
      check("timeout writes", 32'(exp_q.size()), 32'd0);

      // Reset in the 3rd write cycle of byte 10, then a clean upload of sprite 0.
      make_sprite(0, 1'b0, 256);
      start_upload(0);
      for (int b = 0; b <= 10; b++) send_byte(bytes_q[b], 1'b0, 1'b0);
      @(posedge clock);
      @(posedge clock);
      #1;
      check("midrst pre wr_en", 32'(wr_en), 32'd1);
      check("midrst pre addr", 32'(wr_address), 32'd42);
      #1;
      reset = 1'b1;
      #1;
      check("midrst wr_en", 32'(wr_en), 32'd0);
      check("midrst busy", 32'(busy), 32'd0);
      check("midrst data_ready", 32'(data_ready), 32'd0);
      check("midrst state", 32'(dbg_state), 32'd0);
      exp_q.delete();
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      full_upload(0, 1'b0, 1'b0, "after_rst");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2_000_000;
      tests++;
      fails++;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      finish_now();
   end

endmodule
